qmult_seq_rnd: RTL

- Parametrised sequential fixed-point multiplier; next generation of the team's shift-and-add Q-format multiplier.
- Operands and result are sign-magnitude: bit N-1 is the sign, bits N-2:0 are the magnitude with Q fractional bits.
- Adds the following over the previous generation:
  - R multiplier bits retired per cycle.
  - valid/ready handshakes on both input and output.
  - Optional round-half-up and saturation.
  - Negative-zero suppression.
- Sits in the datapath wherever a low-area multiply with backpressure is needed.

---
 rtl/qmult_seq_rnd_if.sv | 35 +++
 rtl/qmult_seq_rnd.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/qmult_seq_rnd_if.sv
// ----------------------------------------------------------------------------
// qmult_seq_rnd_if
// Handshake and data bundle for the sequential sign-magnitude Q-format
// multiplier.
//   i_valid / o_ready            : operand-side handshake
//   i_multiplicand, i_multiplier : sign-magnitude operands, N bits each
//   o_valid / i_ready            : result-side handshake
//   o_result                     : sign-magnitude product, N bits
//   o_overflow                   : magnitude overflow, qualified by o_valid
//   o_busy                       : multiplier is computing
// The slave modport is the multiplier; the master modport is its user.
// ----------------------------------------------------------------------------
interface qmult_seq_rnd_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_multiplicand;
  logic [N-1:0] i_multiplier;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_result;
  logic         o_overflow;
  logic         o_busy;

  modport slave (
    input  i_valid, i_multiplicand, i_multiplier, i_ready,
    output o_ready, o_valid, o_result, o_overflow, o_busy
  );

  modport master (
    output i_valid, i_multiplicand, i_multiplier, i_ready,
    input  o_ready, o_valid, o_result, o_overflow, o_busy
  );
endinterface

// File: rtl/qmult_seq_rnd.sv
// ----------------------------------------------------------------------------
// qmult_seq_rnd
// Sequential shift-and-add sign-magnitude fixed-point multiplier. R bits of
// the multiplier magnitude are retired per RUN cycle, then a single FINAL
// cycle applies optional round-half-up, overflow detection, optional
// saturation and negative-zero suppression.
// Ports:
//   i_clk  : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : qmult_seq_rnd_if.slave (operand/result handshakes, o_busy)
// Parameters:
//   N (word width incl. sign), Q (fractional bits), R (bits per cycle),
//   ROUND (1 = round half-up), SAT (1 = saturate on overflow)
// ----------------------------------------------------------------------------
module qmult_seq_rnd #(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int R     = 1,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic           i_clk,
  input  logic           rst_n,
  qmult_seq_rnd_if.slave bus
);

  localparam int MW  = N - 1;              // magnitude width
  localparam int PW  = 2 * N - 2;          // exact product width
  localparam int K   = (MW + R - 1) / R;   // RUN cycles
  localparam int CW  = (K > 1) ? $clog2(K) : 1;
  localparam int RSH = (Q > 0) ? Q - 1 : 0;
  localparam logic [PW:0] RND_C = (ROUND == 1 && Q > 0) ?
                                  ({{PW{1'b0}}, 1'b1} << RSH) : {(PW+1){1'b0}};

  // Elaboration-time rejection of unsupported parameter sets
  generate
    if (N < 4 || Q < 0 || Q > N - 2 || R < 1 || R > N - 1 ||
        (ROUND != 0 && ROUND != 1) || (SAT != 0 && SAT != 1)) begin : g_bad_param
      $error("qmult_seq_rnd: illegal parameter combination");
    end
    if ($bits(bus.o_result) != N) begin : g_bad_if_width
      $error("qmult_seq_rnd: interface width differs from N");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_a_sh;     // multiplicand magnitude, pre-shifted to the current digit
  logic [MW-1:0]   r_b_sh;     // remaining multiplier magnitude bits, LSB = current digit
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_ready;
  logic            r_busy;
  logic            r_valid;
  logic [N-1:0]    r_result;
  logic            r_overflow;

  logic [PW-1:0]   w_pp;
  logic [PW:0]     w_m;
  logic            w_ovf;
  logic [MW-1:0]   w_mag;
  logic            w_sgn;

  // Partial product of the shifted multiplicand and one R-bit digit. Bits
  // shifted beyond PW can only belong to digits that are zero, so the
  // truncation never loses product bits.
  function automatic logic [PW-1:0] digit_pp(input logic [PW-1:0] a,
                                             input logic [R-1:0]  d);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    for (int i = 0; i < R; i++) begin
      p = p + (d[i] ? (a << i) : {PW{1'b0}});
    end
    return p;
  endfunction

  assign w_pp  = digit_pp(r_a_sh, r_b_sh[R-1:0]);
  // One extra bit so the rounding increment can never wrap.
  assign w_m   = {1'b0, r_acc} + RND_C;
  assign w_ovf = |(w_m >> (MW + Q));
  assign w_mag = (w_ovf && SAT == 1) ? {MW{1'b1}} : MW'(w_m >> Q);
  // A zero magnitude always reports a positive sign.
  assign w_sgn = (w_mag == {MW{1'b0}}) ? 1'b0 : r_sign;

  // Control FSM and datapath; all outputs are registered
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_a_sh     <= {PW{1'b0}};
      r_b_sh     <= {MW{1'b0}};
      r_acc      <= {PW{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_sign     <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= {N{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_valid && r_ready) begin
            r_a_sh     <= {{(PW-MW){1'b0}}, bus.i_multiplicand[MW-1:0]};
            r_b_sh     <= bus.i_multiplier[MW-1:0];
            r_sign     <= bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1];
            r_acc      <= {PW{1'b0}};
            r_cnt      <= {CW{1'b0}};
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc  <= r_acc + w_pp;
          r_a_sh <= r_a_sh << R;
          r_b_sh <= r_b_sh >> R;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(K - 1)) begin
            r_state <= ST_FINAL;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_FINAL: begin
          r_result   <= {w_sgn, w_mag};
          r_overflow <= w_ovf;
          r_busy     <= 1'b0;
          r_valid    <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready    = r_ready;
  assign bus.o_busy     = r_busy;
  assign bus.o_valid    = r_valid;
  assign bus.o_result   = r_result;
  assign bus.o_overflow = r_overflow;

endmodule
